// File: rtl/mpu_matrix_loader.sv
// Producer side of the MPU packed-matrix interface: assembles a row-major byte
// stream into the packed DIM_MAX x DIM_MAX matrix bus and hands it off with valid/ready.
module mpu_matrix_loader #(
    parameter int DIM_MAX = 5,
    parameter int ELEM_W  = 8
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic [7:0]                            size_in,
    input  logic [7:0]                            in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [0:DIM_MAX*DIM_MAX*ELEM_W-1]     matrix,
    output logic [7:0]                            size,
    output logic                                  matrix_valid,
    input  logic                                  matrix_ready,
    output logic                                  busy,
    output logic                                  error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_d;
    logic [7:0] row;
    logic [7:0] col;
    logic       size_legal;
    logic       accept;
    logic       last_beat;
    int         elem_base;

    assign size_legal   = (size_in != 8'd0) && (size_in <= 8'(DIM_MAX));
    assign in_ready     = (state == LOAD);
    assign matrix_valid = (state == DONE);
    assign busy         = (state != IDLE);
    assign accept       = in_valid && in_ready;
    assign last_beat    = (row == size - 8'd1) && (col == size - 8'd1);

    always_comb begin
        elem_base = (int'(row) * DIM_MAX + int'(col)) * ELEM_W;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (start && size_legal) state_d = LOAD;
            LOAD: if (accept && last_beat) state_d = DONE;
            DONE: if (matrix_ready)        state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            matrix <= '0;
            size   <= '0;
            error  <= 1'b0;
            row    <= '0;
            col    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (size_legal) begin
                            // Clearing here keeps positions outside n x n at zero.
                            size   <= size_in;
                            matrix <= '0;
                            row    <= '0;
                            col    <= '0;
                            error  <= 1'b0;
                        end else begin
                            error  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        matrix[elem_base +: ELEM_W] <= in_data;
                        if (col == size - 8'd1) begin
                            col <= '0;
                            row <= row + 8'd1;
                        end else begin
                            col <= col + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed bench for mpu_matrix_loader: hand-built expected matrices checked with
// immediate assertions after each step.
module tb_mpu_matrix_loader;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start;
    logic [7:0]   size_in;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [0:199] matrix;
    logic [7:0]   size;
    logic         matrix_valid;
    logic         matrix_ready;
    logic         busy;
    logic         error;

    logic [0:199] exp_m;
    int           total = 0;
    int           passed = 0;
    int           failed = 0;

    mpu_matrix_loader dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .size_in      (size_in),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .matrix       (matrix),
        .size         (size),
        .matrix_valid (matrix_valid),
        .matrix_ready (matrix_ready),
        .busy         (busy),
        .error        (error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " matrix"},       matrix,       '0);
        check({tag, " size"},         size,         '0);
        check({tag, " in_ready"},     in_ready,     '0);
        check({tag, " matrix_valid"}, matrix_valid, '0);
        check({tag, " busy"},         busy,         '0);
        check({tag, " error"},        error,        '0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; size_in = 8'd0; in_data = 8'd0;
        in_valid = 1'b0; matrix_ready = 1'b0;
        tick(); tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // Size 2: 3, -1, 4, 2 with valid held high
        start = 1'b1; size_in = 8'd2;
        tick();
        start = 1'b0;
        check("s2 in_ready after start", in_ready, 1'b1);
        check("s2 busy after start", busy, 1'b1);
        in_valid = 1'b1;
        in_data = 8'd3;  tick();
        in_data = 8'hFF; tick();
        in_data = 8'd4;  tick();
        check("s2 valid before last beat", matrix_valid, 1'b0);
        in_data = 8'd2;  tick();
        in_valid = 1'b0;
        check("s2 valid at 5 cycles", matrix_valid, 1'b1);
        check("s2 in_ready in done", in_ready, 1'b0);
        exp_m = '0;
        exp_m[0*8 +: 8] = 8'h03;
        exp_m[1*8 +: 8] = 8'hFF;
        exp_m[5*8 +: 8] = 8'h04;
        exp_m[6*8 +: 8] = 8'h02;
        check("s2 matrix", matrix, exp_m);
        check("s2 size", size, 8'd2);
        matrix_ready = 1'b1;
        tick();
        matrix_ready = 1'b0;
        check("s2 valid after accept", matrix_valid, 1'b0);
        check("s2 busy after accept", busy, 1'b0);
        check("s2 matrix retained", matrix, exp_m);

        // Size 5 with in_valid toggling
        start = 1'b1; size_in = 8'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 48; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 8'(i / 2 + 1);
            tick();
            if (i == 47) check("s5 in_ready before last", in_ready, 1'b1);
        end
        check("s5 in_ready after 25th", in_ready, 1'b0);
        check("s5 valid", matrix_valid, 1'b1);
        for (int k = 0; k < 25; k++) exp_m[k*8 +: 8] = 8'(k + 1);
        check("s5 matrix", matrix, exp_m);
        in_valid = 1'b1; in_data = 8'hAA;
        tick();
        in_valid = 1'b0;
        check("s5 26th beat ignored", matrix, exp_m);
        check("s5 size", size, 8'd5);
        matrix_ready = 1'b1;
        tick();
        matrix_ready = 1'b0;

        // Size 1 with a long hold on matrix_ready
        start = 1'b1; size_in = 8'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'hF9;
        tick();
        in_valid = 1'b0;
        exp_m = '0;
        exp_m[0 +: 8] = 8'hF9;
        for (int i = 0; i < 10; i++) begin
            check("s1 hold valid", matrix_valid, 1'b1);
            check("s1 hold in_ready", in_ready, 1'b0);
            check("s1 hold matrix", matrix, exp_m);
            tick();
        end
        check("s1 size", size, 8'd1);
        matrix_ready = 1'b1;
        tick();
        matrix_ready = 1'b0;
        check("s1 valid after accept", matrix_valid, 1'b0);
        check("s1 busy after accept", busy, 1'b0);

        // Illegal sizes 0 and 6
        start = 1'b1; size_in = 8'd0;
        tick();
        check("ill0 error", error, 1'b1);
        check("ill0 busy", busy, 1'b0);
        check("ill0 in_ready", in_ready, 1'b0);
        check("ill0 matrix", matrix, exp_m);
        size_in = 8'd6;
        tick();
        start = 1'b0;
        check("ill6 error", error, 1'b1);
        check("ill6 busy", busy, 1'b0);
        check("ill6 matrix", matrix, exp_m);
        check("ill6 size", size, 8'd1);

        // Size 3 clears error; start (size 2) held asserted through LOAD and DONE
        start = 1'b1; size_in = 8'd3;
        tick();
        size_in = 8'd2;
        check("s3 error cleared", error, 1'b0);
        check("s3 busy", busy, 1'b1);
        in_valid = 1'b1;
        for (int b = 0; b < 9; b++) begin
            in_data = 8'(b + 1);
            tick();
        end
        in_valid = 1'b0;
        exp_m = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                exp_m[(r*5 + c)*8 +: 8] = 8'(r*3 + c + 1);
        check("s3 valid", matrix_valid, 1'b1);
        check("s3 matrix", matrix, exp_m);
        check("s3 size", size, 8'd3);
        tick();
        check("s3 start in done valid", matrix_valid, 1'b1);
        check("s3 start in done matrix", matrix, exp_m);
        check("s3 start in done size", size, 8'd3);
        check("s3 start in done error", error, 1'b0);
        start = 1'b0; matrix_ready = 1'b1;
        tick();
        matrix_ready = 1'b0;
        check("s3 busy after accept", busy, 1'b0);

        // Reset in the middle of a size-4 load
        start = 1'b1; size_in = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h55;
        for (int b = 0; b < 7; b++) tick();
        in_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        check_reset_values("midload reset");
        reset_n = 1'b1;
        start = 1'b1; size_in = 8'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h09;
        for (int b = 0; b < 9; b++) tick();
        in_valid = 1'b0;
        exp_m = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                exp_m[(r*5 + c)*8 +: 8] = 8'h09;
        check("post-reset valid", matrix_valid, 1'b1);
        check("post-reset matrix", matrix, exp_m);
        check("post-reset size", size, 8'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
